// File: rtl/riscv_pkg.sv
// Shared trap/cause definitions for the pipeline and trap controller.
// Holds exception codes, the interrupt cause table and the FSM state type.
package riscv_pkg;

    typedef enum logic [4:0] {
        EXC_INSTR_MISALIGN = 5'd0,
        EXC_INSTR_FAULT    = 5'd1,
        EXC_ILLEGAL        = 5'd2,
        EXC_BREAKPOINT     = 5'd3,
        EXC_LOAD_MISALIGN  = 5'd4,
        EXC_LOAD_FAULT     = 5'd5,
        EXC_STORE_MISALIGN = 5'd6,
        EXC_STORE_FAULT    = 5'd7,
        EXC_ECALL_M        = 5'd11
    } exc_code_e;

    localparam logic [4:0] IRQ_M_EXTERNAL = 5'd11;
    localparam logic [4:0] IRQ_M_SOFTWARE = 5'd3;
    localparam logic [4:0] IRQ_M_TIMER    = 5'd7;

    localparam int MCAUSE_INT_BIT = 31;

    typedef enum logic {
        IDLE,
        FLUSH
    } ctrl_state_e;

    // Line index -> cause code; index 0 is the highest priority line.
    function automatic logic [4:0] irq_code(input logic [31:0] idx);
        case (idx)
            32'd0:   irq_code = IRQ_M_EXTERNAL;
            32'd1:   irq_code = IRQ_M_SOFTWARE;
            32'd2:   irq_code = IRQ_M_TIMER;
            default: irq_code = 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_trap_ctrl_if.sv
// Signal bundle between hazard unit / WB / CSR / fetch and the controller.
// slave: controller side; master: environment side.
interface pipe_trap_ctrl_if #(
    parameter int NSTAGE  = 5,
    parameter int IRQ_NUM = 3
);
    logic [NSTAGE-1:0]  stall_req;
    logic               branch_taken;
    logic               jump_taken;
    logic [31:0]        br_target;
    logic               fence_i;
    logic [31:0]        fence_pc;
    logic               wb_valid;
    logic [31:0]        pc_wb;
    logic               exc_wb;
    logic [4:0]         exc_code_wb;
    logic               mret_wb;
    logic [IRQ_NUM-1:0] irq_pending;
    logic [IRQ_NUM-1:0] irq_enable;
    logic               mstatus_mie;
    logic [31:0]        mtvec;
    logic [31:0]        mepc;
    logic [NSTAGE-1:0]  stall_o;
    logic [NSTAGE-1:0]  flush_o;
    logic               set_pc_valid;
    logic [31:0]        set_pc;
    logic               mcause_update;
    logic [31:0]        mcause_o;
    logic               mepc_update;
    logic [31:0]        mepc_o;
    logic               mret_done;
    logic               busy;

    modport slave (
        input  stall_req, branch_taken, jump_taken, br_target,
        input  fence_i, fence_pc, wb_valid, pc_wb, exc_wb,
        input  exc_code_wb, mret_wb, irq_pending, irq_enable,
        input  mstatus_mie, mtvec, mepc,
        output stall_o, flush_o, set_pc_valid, set_pc,
        output mcause_update, mcause_o, mepc_update, mepc_o,
        output mret_done, busy
    );

    modport master (
        output stall_req, branch_taken, jump_taken, br_target,
        output fence_i, fence_pc, wb_valid, pc_wb, exc_wb,
        output exc_code_wb, mret_wb, irq_pending, irq_enable,
        output mstatus_mie, mtvec, mepc,
        input  stall_o, flush_o, set_pc_valid, set_pc,
        input  mcause_update, mcause_o, mepc_update, mepc_o,
        input  mret_done, busy
    );
endinterface

// File: rtl/pipe_trap_ctrl_irq_prio_enc.sv
// Lowest-index-first priority encoder for interrupt lines.
// Ports: req (N lines) -> valid (any set), idx (winning line).
module irq_prio_enc #(
    parameter int N  = 3,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    output logic          valid,
    output logic [IW-1:0] idx
);
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                idx   = IW'(i);
            end
        end
    end
endmodule

// File: rtl/pipe_trap_ctrl.sv
// Pipeline stall/flush and trap controller (IDLE/FLUSH FSM, mepc/mcause).
// Ports: clk, reset_n, bus (pipe_trap_ctrl_if.slave). Option: MTVEC_VECTORED_EN.
module pipe_trap_ctrl
    import riscv_pkg::*;
#(
    parameter int NSTAGE       = 5,
    parameter int BR_STAGE     = 2,
    parameter int FLUSH_CYCLES = 1,
    parameter int IRQ_NUM      = 3
) (
    input  logic           clk,
    input  logic           reset_n,
    pipe_trap_ctrl_if.slave bus
);
    localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam int IW = (IRQ_NUM > 1) ? $clog2(IRQ_NUM) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(FLUSH_CYCLES - 1);

    ctrl_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   tgt_q, tgt_d;
    logic          mret_q, mret_d;

    logic          irq_v;
    logic [IW-1:0] irq_idx;
    logic          idle;
    logic          irq_take;
    logic          trap_req;
    logic          mret_req;
    logic          br_req;
    logic [4:0]    code;
    logic [31:0]   base;
    logic [31:0]   trap_tgt;
    logic [NSTAGE-1:0] stall_v;
    logic [NSTAGE-1:0] bub_v;
    logic [NSTAGE-1:0] flush_v;
    logic          spv;
    logic [31:0]   spc;
    logic          mcu;
    logic [31:0]   mcause_v;
    logic          mepu;
    logic [31:0]   mepc_v;
    logic          mdone;

    irq_prio_enc #(.N(IRQ_NUM), .IW(IW)) u_enc (
        .req   (bus.irq_pending & bus.irq_enable),
        .valid (irq_v),
        .idx   (irq_idx)
    );

    assign idle     = (state_q == IDLE);
    assign irq_take = bus.mstatus_mie & irq_v;
    assign trap_req = idle & bus.wb_valid & (bus.exc_wb | irq_take);
    assign mret_req = idle & bus.wb_valid & bus.mret_wb & ~trap_req;
    assign br_req   = bus.branch_taken | bus.jump_taken;
    assign code     = bus.exc_wb ? bus.exc_code_wb
                                 : irq_code(32'(irq_idx));
    assign base     = bus.mtvec & 32'hFFFF_FFFC;

`ifdef MTVEC_VECTORED_EN
    // Vectored mode only offsets interrupts; exceptions use the base.
    assign trap_tgt = (bus.mtvec[1:0] == 2'b01 && !bus.exc_wb)
                    ? base + {25'd0, code, 2'b00}
                    : base;
`else
    assign trap_tgt = base;
`endif

    // A hold at stage i freezes everything upstream of it.
    always_comb begin
        logic acc;
        acc     = 1'b0;
        stall_v = '0;
        for (int i = NSTAGE - 1; i >= 0; i--) begin
            acc        = acc | bus.stall_req[i];
            stall_v[i] = acc;
        end
    end

    // Bubble into the first stage that keeps moving below a frozen one.
    always_comb begin
        bub_v = '0;
        for (int i = 1; i < NSTAGE; i++) begin
            bub_v[i] = stall_v[i-1] & ~stall_v[i];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tgt_q   <= '0;
            mret_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tgt_q   <= tgt_d;
            mret_q  <= mret_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        tgt_d    = tgt_q;
        mret_d   = mret_q;
        flush_v  = '0;
        spv      = 1'b0;
        spc      = '0;
        mcu      = 1'b0;
        mcause_v = '0;
        mepu     = 1'b0;
        mepc_v   = '0;
        mdone    = 1'b0;
        unique case (state_q)
            IDLE: begin
                flush_v = bub_v;
                if (trap_req) begin
                    mcu      = 1'b1;
                    mepu     = 1'b1;
                    mcause_v = 32'(code);
                    mcause_v[MCAUSE_INT_BIT] = ~bus.exc_wb;
                    mepc_v   = bus.pc_wb;
                    flush_v[NSTAGE-1] = 1'b1;
                    tgt_d    = trap_tgt;
                    mret_d   = 1'b0;
                    cnt_d    = CNT_LOAD;
                    state_d  = FLUSH;
                end else if (mret_req) begin
                    tgt_d    = bus.mepc;
                    mret_d   = 1'b1;
                    cnt_d    = CNT_LOAD;
                    state_d  = FLUSH;
                end else if (br_req) begin
                    if (!stall_v[BR_STAGE]) begin
                        spv = 1'b1;
                        spc = bus.br_target;
                        flush_v[BR_STAGE-1:0] = '1;
                    end
                end else if (bus.fence_i) begin
                    spv        = 1'b1;
                    spc        = bus.fence_pc;
                    flush_v[0] = 1'b1;
                end
            end
            FLUSH: begin
                flush_v = '1;
                if (cnt_q == '0) begin
                    spv     = 1'b1;
                    spc     = tgt_q;
                    mdone   = mret_q;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.stall_o       = idle ? stall_v : '0;
    assign bus.flush_o       = flush_v;
    assign bus.set_pc_valid  = spv;
    assign bus.set_pc        = spc;
    assign bus.mcause_update = mcu;
    assign bus.mcause_o      = mcause_v;
    assign bus.mepc_update   = mepu;
    assign bus.mepc_o        = mepc_v;
    assign bus.mret_done     = mdone;
    assign bus.busy          = ~idle;

endmodule
